// File: rtl/adc_capture_pkg.sv
// ============================================================================
// Module      : adc_capture_pkg
// Description : Shared types and width helper for the ADC capture controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_capture_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cap_state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_capture_ctrl_if.sv
// ============================================================================
// Module      : adc_capture_ctrl_if
// Description : Valid/ready sample stream from the capture FIFO to a consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_capture_ctrl_if #(
    parameter int DATA_W = 13
);
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

`default_nettype wire

// File: rtl/adc_sample_fifo.sv
// ============================================================================
// Module      : adc_sample_fifo
// Description : Show-ahead sample FIFO; a push while full is accepted only
//               when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_fifo
    import adc_capture_pkg::*;
#(
    parameter int DATA_W     = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic                            clk,
    input  wire logic                            rstn,
    input  wire logic                            push,
    input  wire logic [DATA_W-1:0]               push_data,
    input  wire logic                            pop,
    output logic      [DATA_W-1:0]               rd_data,
    output logic                                 full,
    output logic                                 empty,
    output logic      [level_w(FIFO_DEPTH)-1:0]  level
);
    localparam int                     c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int                     c_lvl_w   = level_w(FIFO_DEPTH);
    localparam logic [c_lvl_w-1:0]     c_lvl_max = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_lvl_w-1:0]     c_lvl_one = c_lvl_w'(1);
    localparam logic [c_ptr_w-1:0]     c_ptr_one = c_ptr_w'(1);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_level == c_lvl_max);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Forced to zero when empty so the output bus is clean out of reset.
    assign rd_data   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
// ============================================================================
// Module      : adc_capture_ctrl
// Description : Drives a divided ADC clock, latches adc_data once per period
//               and queues samples (optionally averaged when the macro
//               ADC_CAPTURE_AVG_EN is defined) into a show-ahead FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DATA_W       = 13,
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_PHASE = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int AVG_LOG2     = 2
) (
    input  wire logic                           clk,
    input  wire logic                           rstn,
    input  wire logic                           enable,
    output logic                                adc_clk,
    input  wire logic [DATA_W-1:0]              adc_data,
    adc_capture_ctrl_if.master                  m_if,
    output logic                                overflow,
    input  wire logic                           clr_ovf,
    output logic      [level_w(FIFO_DEPTH)-1:0] fifo_level
);
    localparam int                 c_div_w    = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLK_DIV / 2);
    localparam logic [c_div_w-1:0] c_phase    = c_div_w'(SAMPLE_PHASE);

    cap_state_t          r_state;
    logic [c_div_w-1:0]  r_div_cnt;
    logic                r_adc_clk;
    logic [DATA_W-1:0]   r_cap_reg;
    logic                r_cap_vld;
    logic                r_push;
    logic [DATA_W-1:0]   w_push_data;
    logic                r_overflow;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_ovf_evt;
    logic [DATA_W-1:0]   w_rd_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_adc_clk <= 1'b0;
            r_cap_reg <= '0;
            r_cap_vld <= 1'b0;
        end else begin
            r_adc_clk <= (r_state == RUN) && (r_div_cnt >= c_div_half);
            r_cap_vld <= (r_state == RUN) && (r_div_cnt == c_phase);
            if ((r_state == RUN) && (r_div_cnt == c_phase)) begin
                r_cap_reg <= adc_data;
            end
            case (r_state)
                IDLE: begin
                    r_div_cnt <= '0;
                    if (enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Only leave at a period boundary so adc_clk never glitches.
                    if (r_div_cnt == c_div_last) begin
                        r_div_cnt <= '0;
                        if (!enable) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_div_w'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_div_cnt <= '0;
                end
            endcase
        end
    end

`ifdef ADC_CAPTURE_AVG_EN
    localparam int c_acc_w = DATA_W + AVG_LOG2;

    logic [c_acc_w-1:0]  r_acc;
    logic [c_acc_w-1:0]  w_acc_sum;
    logic [AVG_LOG2-1:0] r_avg_cnt;
    logic [DATA_W-1:0]   r_avg_data;

    assign w_acc_sum   = r_acc + c_acc_w'(r_cap_reg);
    assign w_push_data = r_avg_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc      <= '0;
            r_avg_cnt  <= '0;
            r_avg_data <= '0;
            r_push     <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (r_cap_vld) begin
                r_avg_cnt <= r_avg_cnt + AVG_LOG2'(1);
                if (&r_avg_cnt) begin
                    r_push     <= 1'b1;
                    r_avg_data <= DATA_W'(w_acc_sum >> AVG_LOG2);
                    r_acc      <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end else if (r_state == IDLE) begin
                r_acc     <= '0;
                r_avg_cnt <= '0;
            end
        end
    end
`else
    assign w_push_data = r_cap_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_push <= 1'b0;
        end else begin
            r_push <= r_cap_vld;
        end
    end

    // Averaging depth has no meaning in this build.
    if (AVG_LOG2 < 0) begin : g_avg_unused
    end
`endif

    adc_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (r_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .rd_data   (w_rd_data),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    assign w_pop     = !w_empty && m_if.m_ready;
    assign w_ovf_evt = r_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign m_if.m_data  = w_rd_data;
    assign m_if.m_valid = !w_empty;
    assign overflow     = r_overflow;
    assign adc_clk      = r_adc_clk;

endmodule

`default_nettype wire
